// File: rtl/uart_rxd.sv
// rtl/uart_rxd.sv - 8N1 UART receiver, LSB first, with one-entry valid/ready output register
// Frame errors and overruns are reported as single-cycle pulses on the STOP decision edge.
module uart_rxd #(
  parameter int bps  = 115200,
  parameter int freq = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RXD,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] RXD_data,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV  = freq / bps;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          rx_s1_q, rx_s2_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= RXD;
      rx_s2_q <= rx_s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_s2_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == HALF_M1) begin
          if (!rx_s2_q) begin
            state_d = S_DATA;
            cnt_d   = '0;
            idx_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == DIV_M1) begin
          sh_d  = {rx_s2_q, sh_q[7:1]};
          cnt_d = '0;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == DIV_M1) begin
          cnt_d = '0;
          if (rx_s2_q) begin
            // A same-edge accept frees the slot, so only an unconsumed byte is lost.
            data_d  = sh_q;
            valid_d = 1'b1;
            ovr_d   = valid_q && !ready;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_BREAK: begin
        if (rx_s2_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      sh_q    <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign valid     = valid_q;
  assign RXD_data  = data_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rxd.sv
// tb/tb_uart_rxd.sv - self-checking bench for uart_rxd against a frame-timing reference model
// The model schedules load/error/busy events from bit-period arithmetic and is compared every cycle.
module tb_uart_rxd;

  localparam int BPS   = 10;
  localparam int FREQ  = 175;
  localparam int DIV   = FREQ / BPS;          // 17, truncated
  localparam int HALF  = DIV / 2;             // 8, truncated
  localparam int LAT   = 3 + HALF + 9 * DIV;  // line edge to STOP decision edge
  localparam int NCYC  = 16384;
  localparam int EXTRA = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RXD = 1'b1;
  logic       ready = 1'b0;
  logic       valid;
  logic [7:0] RXD_data;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  uart_rxd #(.bps(BPS), .freq(FREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .RXD       (RXD),
    .ready     (ready),
    .valid     (valid),
    .RXD_data  (RXD_data),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         m_ferr = 1'b0;
  bit         m_ovr = 1'b0;
  bit         ev_load [NCYC];
  logic [7:0] ev_data [NCYC];
  bit         ev_ferr [NCYC];
  bit         exp_busy[NCYC];
  logic [7:0] acc_q[$];
  int         rise_cyc = -1;
  logic       valid_prev = 1'b0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: applies the scheduled STOP decisions and the handshake rule per edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
    end else if (cyc < NCYC) begin
      if (valid && ready) acc_q.push_back(RXD_data);
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (ev_load[cyc]) begin
        m_ovr   = m_valid && !ready;
        m_valid = 1'b1;
        m_data  = ev_data[cyc];
      end else if (ev_ferr[cyc]) begin
        m_ferr = 1'b1;
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cyc > 0 && cyc < NCYC) begin
      chk("valid", 32'(valid), 32'(m_valid));
      chk("RXD_data", 32'(RXD_data), 32'(m_data));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("busy", 32'(busy), 32'(exp_busy[cyc]));
      if (valid && !valid_prev) rise_cyc = cyc;
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
    end
    valid_prev = valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sched_frame(input logic [7:0] b, input bit stopv, input int k, input int busy_end);
    int l;
    l = k + LAT;
    if (stopv) begin
      ev_load[l] = 1'b1;
      ev_data[l] = b;
    end else begin
      ev_ferr[l] = 1'b1;
    end
    for (int e = k + 3; e < busy_end; e++) exp_busy[e] = 1'b1;
  endtask

  task automatic drive(input logic [7:0] b, input bit stopv, input int nbits);
    logic [9:0] fr;
    fr = {stopv, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      RXD = fr[i];
      tick(DIV);
    end
  endtask

  task automatic send(input logic [7:0] b);
    sched_frame(b, 1'b1, cyc, cyc + LAT);
    drive(b, 1'b1, 10);
  endtask

  task automatic consume;
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  initial begin
    int k, m, base, fb, ob;
    @(negedge clk);
    tick(2);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset data", 32'(RXD_data), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset pulses", 32'({frame_err, overrun}), 32'd0);
    rst = 1'b0;
    tick(3);

    // 0x55 with ready low: latency 3 + 8 + 153 = 164 edges after the line falls.
    k = cyc;
    send(8'h55);
    chk("latency 0x55", 32'(rise_cyc - k), 32'd164);
    chk("data 0x55", 32'(RXD_data), 32'h55);
    chk("valid held 0x55", 32'(valid), 32'd1);
    consume();
    chk("valid cleared", 32'(valid), 32'd0);

    // Reset in the middle of a frame, line released high.
    k = cyc;
    for (int e = k + 3; e < k + LAT; e++) exp_busy[e] = 1'b1;
    drive(8'hA5, 1'b1, 4);
    #2 rst = 1'b1;
    #1;
    chk("midreset valid", 32'(valid), 32'd0);
    chk("midreset data", 32'(RXD_data), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset pulses", 32'({frame_err, overrun}), 32'd0);
    RXD = 1'b1;
    for (int e = cyc; e < NCYC; e++) begin
      exp_busy[e] = 1'b0;
      ev_load[e]  = 1'b0;
      ev_ferr[e]  = 1'b0;
    end
    tick(3);
    rst = 1'b0;
    tick(5);
    send(8'hA5);
    chk("data 0xA5", 32'(RXD_data), 32'hA5);
    consume();

    // Back-to-back frames, one stop bit, ready tied high.
    ready = 1'b1;
    base = acc_q.size();
    fb = ferr_cnt;
    ob = ovr_cnt;
    send(8'h00);
    send(8'hFF);
    send(8'h81);
    tick(2);
    ready = 1'b0;
    chk("b2b count", 32'(acc_q.size() - base), 32'd3);
    if (acc_q.size() - base == 3) begin
      chk("b2b byte0", 32'(acc_q[base]), 32'h00);
      chk("b2b byte1", 32'(acc_q[base + 1]), 32'hFF);
      chk("b2b byte2", 32'(acc_q[base + 2]), 32'h81);
    end
    chk("b2b no errors", 32'((ferr_cnt - fb) + (ovr_cnt - ob)), 32'd0);

    // Overrun: two bytes with ready low.
    ob = ovr_cnt;
    send(8'h12);
    send(8'h34);
    chk("overrun count", 32'(ovr_cnt - ob), 32'd1);
    chk("overrun data", 32'(RXD_data), 32'h34);
    chk("overrun valid", 32'(valid), 32'd1);

    // Accept on the same edge a new byte loads.
    ob = ovr_cnt;
    k = cyc;
    fork
      send(8'h56);
      begin
        tick(LAT - 1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
      end
    join
    chk("same-edge valid", 32'(valid), 32'd1);
    chk("same-edge data", 32'(RXD_data), 32'h56);
    chk("same-edge no overrun", 32'(ovr_cnt - ob), 32'd0);
    consume();

    // Short glitch shorter than half a bit: false start.
    k = cyc;
    for (int e = k + 3; e < k + 3 + HALF; e++) exp_busy[e] = 1'b1;
    RXD = 1'b0;
    tick(4);
    RXD = 1'b1;
    tick(2 * DIV);
    chk("glitch valid", 32'(valid), 32'd0);
    chk("glitch busy", 32'(busy), 32'd0);

    // Stop bit low, line held low, then released.
    fb = ferr_cnt;
    k = cyc;
    m = k + 10 * DIV + EXTRA;
    sched_frame(8'h3C, 1'b0, k, m + 3);
    drive(8'h3C, 1'b0, 10);
    tick(EXTRA);
    RXD = 1'b1;
    tick(2 * DIV);
    chk("frame_err count", 32'(ferr_cnt - fb), 32'd1);
    chk("frame_err valid", 32'(valid), 32'd0);
    chk("frame_err data", 32'(RXD_data), 32'h56);

    send(8'h3C);
    chk("data 0x3C", 32'(RXD_data), 32'h3C);
    chk("valid 0x3C", 32'(valid), 32'd1);
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #(NCYC * 10);
    $display("FAIL watchdog: simulation exceeded %0d cycles", NCYC);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_rxd.md
# uart_rxd

UART receiver, 8N1, LSB first: the receive side paired with the team's TXD transmitter. The block synchronises the asynchronous serial input and times each bit with its own baud counter derived from `freq/bps`. Each assembled byte is presented on a one-entry valid/ready output register. Frame errors and overruns are reported as one-cycle pulses.

## Interface
- `bps`, 115200: serial bit rate.
- `freq`, 50_000_000: `clk` frequency in Hz.
- Derived constant: `DIV = freq/bps`, integer truncation; 434 at defaults.
- Derived constant: `HALF = DIV/2`, truncated; 217 at defaults.
- `DIV >= 4` is required; behaviour is undefined below that.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `RXD`  in  1  serial line; idles high; asynchronous to `clk`.
- `ready`  in  1  consumer accepts the byte when `valid && ready`.
- `valid`  out  1  `RXD_data` holds an unconsumed byte.
- `RXD_data`  out  8  received byte.
- `busy`  out  1  high whenever the state is not IDLE.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a byte was lost to overwrite.

## Operation
- **Synchroniser:** two flops, `rx_s1` then `rx_s2`, both reset to 1. The FSM uses only `rx_s2`.
- **Registers:** bit counter `cnt`, wide enough for `DIV-1`; 3-bit bit index `idx`; 8-bit shift register `sh`.
- **IDLE**
  - `rx_s2 == 0` → START, `cnt <= 0`.
- **START**
  - `cnt` increments each cycle.
  - At `cnt == HALF-1`: if `rx_s2 == 0` → DATA with `cnt <= 0`, `idx <= 0`.
  - Otherwise it is a false start → IDLE.
- **DATA**
  - `cnt` counts 0..DIV-1.
  - At `cnt == DIV-1`: `sh <= {rx_s2, sh[7:1]}`, `cnt <= 0`, `idx <= idx+1`.
  - After the bit with `idx == 7` → STOP.
- **STOP**
  - At `cnt == DIV-1`, if `rx_s2 == 1`:
    - `RXD_data <= sh`, `valid <= 1`.
    - If `valid` was 1 and is not being consumed this cycle, pulse `overrun`; the new byte overwrites the old one.
    - Next state → IDLE.
  - At `cnt == DIV-1`, if `rx_s2 == 0`:
    - Pulse `frame_err`; `RXD_data` and `valid` are unchanged.
    - Next state → BREAK.
- **BREAK**
  - Wait for `rx_s2 == 1`, then → IDLE. This prevents a held-low line from re-triggering reception.
- **Handshake**
  - `valid && ready` at a rising edge clears `valid`, unless a new byte is loaded on that same edge.
  - Same-edge case: `valid` stays 1, `RXD_data` takes the new byte, and there is no overrun.
  - `ready` is ignored while `valid == 0`.
  - `RXD_data` is stable while `valid == 1`, except on overrun.
- **Reset**
  - Outputs: `valid=0`, `RXD_data=0`, `busy=0`, `frame_err=0`, `overrun=0`.
  - Internals: state = IDLE, `cnt/idx/sh = 0`, synchroniser = 1.
  - Reset mid-frame abandons the frame. Afterwards the block resumes from IDLE; if the line is still low at that point, the rest of the abandoned frame can be misread as a new start bit.

## Timing
- **Latency:** `rx_s2` follows `RXD` after 2 clocks.
  - From the first cycle `rx_s2 == 0` in IDLE, `valid` rises `1 + HALF + 9*DIV` cycles later.
  - At defaults: 4124 clocks after the RXD falling edge + 2 synchroniser cycles = 4126.
- **Sample points:** each bit is sampled at its nominal centre, `HALF + k*DIV` cycles after the start edge, for k = 1..9.
- **Back-to-back frames:** a new start bit can be detected on the cycle after the IDLE transition from STOP, i.e. at the stop-bit midpoint plus 1.
  - The block therefore tolerates transmitters sending 1 stop bit with up to ±2% baud error.
- **Pulse timing:** `frame_err` and `overrun` are high for exactly one clock, on the edge the STOP decision is taken.
- **`busy`:** rises one cycle after `rx_s2` falls in IDLE. It falls on entry to IDLE.

## Test plan
- **Reset:** assert `rst` mid-byte → all outputs 0 immediately. After release with the line idle high, the next valid frame 0xA5 is received correctly.
- **Single byte:** send 0x55 at 115200 baud with `ready=0` → `valid` rises at 4126±2 clocks after the falling edge, `RXD_data=0x55`.
  - Then pulse `ready` → `valid` clears the next edge.
- **Back-to-back with loopback:** drive the TXD transmitter with 0x00, 0xFF, 0x81 and `ready` tied to 1.
  - Required: three `valid` pulses carrying 0x00, 0xFF, 0x81 in order, with no `frame_err` or `overrun`.
- **Overrun:** hold `ready=0` and send 0x12 then 0x34.
  - Required: one `overrun` pulse at the second STOP decision; `RXD_data=0x34`, `valid=1`.
- **Simultaneous accept and load:** assert `ready` exactly on the edge 0x34 loads.
  - Required: `valid` stays 1, no `overrun`.
- **Framing and false start:**
  - Glitch low for 100 clocks → no `busy` after START, no `valid`.
  - Frame 0x3C with stop bit low, line held low 5000 clocks, then high → one `frame_err` pulse, `valid` unchanged, exactly one reception attempt.
  - A subsequent 0x3C is received correctly.
